// File: rtl/rv32i_pkg.sv
// Shared constants and elaboration helpers for the RV32I register file slice.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // True when an ADDR_W-bit address can reach every one of NUM_REGS registers.
    function automatic bit addr_w_ok(input int addr_w, input int num_regs);
        if (addr_w >= 31) begin
            return 1'b1;
        end else begin
            return ((32'sd1 <<< addr_w) >= num_regs);
        end
    endfunction

    // True when the register count lies in the supported 2..32 range.
    function automatic bit num_regs_ok(input int num_regs);
        return (num_regs >= 2) && (num_regs <= 32);
    endfunction

endpackage

// File: rtl/rv32i_gpr_rdport.sv
// One combinational GPR read port: address decode, hardwired-zero and
// out-of-range handling, optional write-back bypass and the RDY flag.
module rv32i_gpr_rdport
    import rv32i_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NREG,
    parameter int ADDR_W   = REG_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              pending,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                dst_addr,
    input  logic [DATA_W-1:0]                dst_data,
    output logic [DATA_W-1:0]                data,
    output logic                             rdy
);

    logic [DATA_W-1:0] sel_data_s;
    logic              sel_pend_s;
    logic              in_range_s;
    logic              is_zero_s;
    logic              valid_s;
    logic              hit_s;

    // Address classification: a readable register is in range and not the hardwired zero.
    assign in_range_s = (32'(addr) < 32'(NUM_REGS));
    assign is_zero_s  = (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    assign valid_s    = in_range_s && !is_zero_s;
    assign hit_s      = (BYPASS != 0) && wr_en && (dst_addr == addr);

    // Decode the stored value and pending bit of the addressed register.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_pend_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                sel_data_s = regs[i];
                sel_pend_s = pending[i];
            end else begin
                sel_data_s = sel_data_s;
                sel_pend_s = sel_pend_s;
            end
        end
    end

    // Output mux: constant zero, forwarded write-back data, or stored data.
    always_comb begin
        data = {DATA_W{1'b0}};
        rdy  = 1'b1;
        if (!valid_s) begin
            data = {DATA_W{1'b0}};
            rdy  = 1'b1;
        end else if (hit_s) begin
            data = dst_data;
            rdy  = 1'b1;
        end else begin
            data = sel_data_s;
            rdy  = !sel_pend_s;
        end
    end

endmodule

// File: rtl/rv32i_gpr_sb.sv
// General-purpose register file with a per-register pending scoreboard.
// Two combinational read ports, one write-back port, issue/flush tracking.
module rv32i_gpr_sb
    import rv32i_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NREG,
    parameter int ADDR_W   = REG_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                I_CLK,
    input  logic                I_RSTN,
    input  logic [ADDR_W-1:0]   I_SRC1_ADDR,
    input  logic [ADDR_W-1:0]   I_SRC2_ADDR,
    output logic [DATA_W-1:0]   O_SRC1_DATA,
    output logic [DATA_W-1:0]   O_SRC2_DATA,
    output logic                O_SRC1_RDY,
    output logic                O_SRC2_RDY,
    input  logic                I_ISSUE_EN,
    input  logic [ADDR_W-1:0]   I_ISSUE_ADDR,
    input  logic                I_WR_EN,
    input  logic [ADDR_W-1:0]   I_DST_ADDR,
    input  logic [DATA_W-1:0]   I_DST_DATA,
    input  logic                I_FLUSH,
    output logic [NUM_REGS-1:0] O_BUSY_VEC
);

    // Reject configurations whose address cannot reach every register.
    if (!addr_w_ok(ADDR_W, NUM_REGS)) begin : g_bad_addr_w
        $fatal(1, "rv32i_gpr_sb: 2**ADDR_W must be >= NUM_REGS");
    end
    if (!num_regs_ok(NUM_REGS)) begin : g_bad_num_regs
        $fatal(1, "rv32i_gpr_sb: NUM_REGS must be within 2..32");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;
    logic [NUM_REGS-1:0]             pend_r;
    logic [NUM_REGS-1:0]             pend_nxt_s;
    logic                            wr_valid_s;
    logic                            issue_valid_s;

    // A write or issue only takes effect on an in-range, non-hardwired register.
    assign wr_valid_s    = I_WR_EN && (32'(I_DST_ADDR) < 32'(NUM_REGS))
                         && !((ZERO_REG != 0) && (I_DST_ADDR == {ADDR_W{1'b0}}));
    assign issue_valid_s = I_ISSUE_EN && (32'(I_ISSUE_ADDR) < 32'(NUM_REGS))
                         && !((ZERO_REG != 0) && (I_ISSUE_ADDR == {ADDR_W{1'b0}}));

    // Register storage: synchronous write-back, cleared by reset.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            regs_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_valid_s && (I_DST_ADDR == ADDR_W'(i))) begin
                    regs_r[i] <= I_DST_DATA;
                end
            end
        end
    end

    // Next pending state: flush beats everything, otherwise issue beats write-back.
    always_comb begin
        pend_nxt_s = pend_r;
        if (I_FLUSH) begin
            pend_nxt_s = {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue_valid_s && (I_ISSUE_ADDR == ADDR_W'(i))) begin
                    pend_nxt_s[i] = 1'b1;
                end else if (wr_valid_s && (I_DST_ADDR == ADDR_W'(i))) begin
                    pend_nxt_s[i] = 1'b0;
                end else begin
                    pend_nxt_s[i] = pend_r[i];
                end
            end
        end
    end

    // Pending flops; these are also the registered busy vector.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign O_BUSY_VEC = pend_r;

    rv32i_gpr_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rdport1 (
        .addr     (I_SRC1_ADDR),
        .regs     (regs_r),
        .pending  (pend_r),
        .wr_en    (I_WR_EN),
        .dst_addr (I_DST_ADDR),
        .dst_data (I_DST_DATA),
        .data     (O_SRC1_DATA),
        .rdy      (O_SRC1_RDY)
    );

    rv32i_gpr_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rdport2 (
        .addr     (I_SRC2_ADDR),
        .regs     (regs_r),
        .pending  (pend_r),
        .wr_en    (I_WR_EN),
        .dst_addr (I_DST_ADDR),
        .dst_data (I_DST_DATA),
        .data     (O_SRC2_DATA),
        .rdy      (O_SRC2_RDY)
    );

endmodule

// File: tb/tb_rv32i_gpr_sb.sv
// Directed scoreboard bench for rv32i_gpr_sb: a default instance (A) and a
// BYPASS=0, NUM_REGS=16 instance (B) sharing the same stimulus.
module tb_rv32i_gpr_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        wr_en;
    logic [4:0]  dst_addr;
    logic [31:0] dst_data;
    logic        flush;

    logic [31:0] a_src1_data, a_src2_data;
    logic        a_src1_rdy, a_src2_rdy;
    logic [31:0] a_busy;
    logic [31:0] b_src1_data, b_src2_data;
    logic        b_src1_rdy, b_src2_rdy;
    logic [15:0] b_busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    rv32i_gpr_sb u_dut_a (
        .I_CLK        (clk),
        .I_RSTN       (rst_n),
        .I_SRC1_ADDR  (src1_addr),
        .I_SRC2_ADDR  (src2_addr),
        .O_SRC1_DATA  (a_src1_data),
        .O_SRC2_DATA  (a_src2_data),
        .O_SRC1_RDY   (a_src1_rdy),
        .O_SRC2_RDY   (a_src2_rdy),
        .I_ISSUE_EN   (issue_en),
        .I_ISSUE_ADDR (issue_addr),
        .I_WR_EN      (wr_en),
        .I_DST_ADDR   (dst_addr),
        .I_DST_DATA   (dst_data),
        .I_FLUSH      (flush),
        .O_BUSY_VEC   (a_busy)
    );

    rv32i_gpr_sb #(
        .NUM_REGS (16),
        .BYPASS   (0)
    ) u_dut_b (
        .I_CLK        (clk),
        .I_RSTN       (rst_n),
        .I_SRC1_ADDR  (src1_addr),
        .I_SRC2_ADDR  (src2_addr),
        .O_SRC1_DATA  (b_src1_data),
        .O_SRC2_DATA  (b_src2_data),
        .O_SRC1_RDY   (b_src1_rdy),
        .O_SRC2_RDY   (b_src2_rdy),
        .I_ISSUE_EN   (issue_en),
        .I_ISSUE_ADDR (issue_addr),
        .I_WR_EN      (wr_en),
        .I_DST_ADDR   (dst_addr),
        .I_DST_DATA   (dst_data),
        .I_FLUSH      (flush),
        .O_BUSY_VEC   (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h with no expected value queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        issue_en   = 1'b0;
        issue_addr = 5'd0;
        wr_en      = 1'b0;
        dst_addr   = 5'd0;
        dst_data   = 32'd0;
        flush      = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        src1_addr = 5'd1;
        src2_addr = 5'd0;
        idle();

        // Reset state
        @(negedge clk);
        #1;
        expect_val("reset_busy_a", 32'h0);          check_obs(a_busy);
        expect_val("reset_busy_b", 32'h0);          check_obs(32'(b_busy));
        expect_val("reset_x1_data", 32'h0);         check_obs(a_src1_data);
        @(negedge clk);
        rst_n = 1'b1;

        // Write and issue x5, then reset asynchronously mid-write
        @(negedge clk);
        wr_en = 1'b1; dst_addr = 5'd5; dst_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd5;
        @(negedge clk);
        idle();
        src1_addr = 5'd5;
        expect_val("x5_written", 32'hDEADBEEF);     expect_val("x5_pending_rdy", 32'h0);
        expect_val("busy_x5", 32'h0000_0020);
        #1;
        check_obs(a_src1_data); check_obs(32'(a_src1_rdy)); check_obs(a_busy);
        wr_en = 1'b1; dst_addr = 5'd5; dst_data = 32'hDEADBEEF;
        #2;
        rst_n = 1'b0;
        expect_val("async_reset_busy", 32'h0);
        #1;
        check_obs(a_busy);
        wr_en = 1'b0;
        expect_val("async_reset_x5", 32'h0);        expect_val("async_reset_x5_rdy", 32'h1);
        #1;
        check_obs(a_src1_data); check_obs(32'(a_src1_rdy));
        @(negedge clk);
        rst_n = 1'b1;

        // Write x7, read it back alongside x0
        @(negedge clk);
        wr_en = 1'b1; dst_addr = 5'd7; dst_data = 32'h12345678;
        @(negedge clk);
        idle();
        src1_addr = 5'd7; src2_addr = 5'd0;
        expect_val("x7_data", 32'h12345678);        expect_val("x7_rdy", 32'h1);
        expect_val("x0_data", 32'h0);               expect_val("x0_rdy", 32'h1);
        #1;
        check_obs(a_src1_data); check_obs(32'(a_src1_rdy));
        check_obs(a_src2_data); check_obs(32'(a_src2_rdy));

        // Writes and issues to x0 are ignored
        @(negedge clk);
        wr_en = 1'b1; dst_addr = 5'd0; dst_data = 32'hFFFFFFFF;
        @(negedge clk);
        idle();
        issue_en = 1'b1; issue_addr = 5'd0;
        @(negedge clk);
        idle();
        src1_addr = 5'd0;
        expect_val("x0_after_write", 32'h0);        expect_val("x0_not_busy", 32'h0);
        #1;
        check_obs(a_src1_data); check_obs(a_busy);

        // Issue x3, then write back x3 with bypass
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd3;
        @(negedge clk);
        idle();
        src1_addr = 5'd3;
        expect_val("busy_x3", 32'h0000_0008);       expect_val("x3_rdy_pending", 32'h0);
        #1;
        check_obs(a_busy); check_obs(32'(a_src1_rdy));
        wr_en = 1'b1; dst_addr = 5'd3; dst_data = 32'hA5A5A5A5;
        expect_val("x3_bypass_data", 32'hA5A5A5A5); expect_val("x3_bypass_rdy", 32'h1);
        #1;
        check_obs(a_src1_data); check_obs(32'(a_src1_rdy));
        @(negedge clk);
        idle();
        expect_val("x3_after_wb_data", 32'hA5A5A5A5);
        expect_val("x3_after_wb_rdy", 32'h1);       expect_val("x3_after_wb_busy", 32'h0);
        #1;
        check_obs(a_src1_data); check_obs(32'(a_src1_rdy)); check_obs(a_busy);

        // Same-cycle issue and write-back to x9: issue wins
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 1'b1; dst_addr = 5'd9; dst_data = 32'h11;
        @(negedge clk);
        idle();
        src1_addr = 5'd9;
        expect_val("x9_busy", 32'h0000_0200);       expect_val("x9_data", 32'h11);
        expect_val("x9_rdy", 32'h0);
        #1;
        check_obs(a_busy); check_obs(a_src1_data); check_obs(32'(a_src1_rdy));

        // Issue x4, x6, x8 then flush with a simultaneous issue of x10
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd4;
        @(negedge clk);
        issue_addr = 5'd6;
        @(negedge clk);
        issue_addr = 5'd8;
        @(negedge clk);
        issue_addr = 5'd10; flush = 1'b1;
        expect_val("busy_before_flush", 32'h0000_0350);
        #1;
        check_obs(a_busy);
        @(negedge clk);
        idle();
        src1_addr = 5'd10;
        expect_val("busy_after_flush", 32'h0);      expect_val("x10_rdy_after_flush", 32'h1);
        #1;
        check_obs(a_busy); check_obs(32'(a_src1_rdy));

        // No-bypass instance: same-cycle read returns old value, out-of-range reads zero
        @(negedge clk);
        wr_en = 1'b1; dst_addr = 5'd2; dst_data = 32'h55;
        src1_addr = 5'd2; src2_addr = 5'd20;
        expect_val("b_x2_old", 32'h0);              expect_val("b_x2_old_rdy", 32'h1);
        expect_val("a_x2_bypass", 32'h55);
        #1;
        check_obs(b_src1_data); check_obs(32'(b_src1_rdy)); check_obs(a_src1_data);
        @(negedge clk);
        wr_en = 1'b1; dst_addr = 5'd20; dst_data = 32'h77;
        expect_val("b_x2_new", 32'h55);             expect_val("b_x20_data", 32'h0);
        expect_val("b_x20_rdy", 32'h1);             expect_val("b_busy", 32'h0);
        #1;
        check_obs(b_src1_data); check_obs(b_src2_data);
        check_obs(32'(b_src2_rdy)); check_obs(32'(b_busy));
        @(negedge clk);
        idle();
        issue_en = 1'b1; issue_addr = 5'd20;
        expect_val("b_x20_after_write", 32'h0);     expect_val("a_x20_after_write", 32'h77);
        #1;
        check_obs(b_src2_data); check_obs(a_src2_data);
        @(negedge clk);
        idle();
        expect_val("b_busy_oob_issue", 32'h0);      expect_val("a_busy_x20", 32'h0010_0000);
        #1;
        check_obs(32'(b_busy)); check_obs(a_busy);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
